// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: AXI4-Lite 2:1 arbiter, fetch (M0) and data (M1)
// onto one memory slave; one outstanding read and one write.
module axi_mem_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter bit PRIO_M1    = 1'b1,
  parameter int MAX_WAIT   = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [AXI_AWIDTH-1:0]   M0_ARADDR,
  input  logic                    M0_ARVALID,
  output logic                    M0_ARREADY,
  output logic [AXI_DWIDTH-1:0]   M0_RDATA,
  output logic [1:0]              M0_RRESP,
  output logic                    M0_RVALID,
  input  logic                    M0_RREADY,
  input  logic [AXI_AWIDTH-1:0]   M1_AWADDR,
  input  logic                    M1_AWVALID,
  output logic                    M1_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   M1_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] M1_WSTRB,
  input  logic                    M1_WVALID,
  output logic                    M1_WREADY,
  output logic [1:0]              M1_BRESP,
  output logic                    M1_BVALID,
  input  logic                    M1_BREADY,
  input  logic [AXI_AWIDTH-1:0]   M1_ARADDR,
  input  logic                    M1_ARVALID,
  output logic                    M1_ARREADY,
  output logic [AXI_DWIDTH-1:0]   M1_RDATA,
  output logic [1:0]              M1_RRESP,
  output logic                    M1_RVALID,
  input  logic                    M1_RREADY,
  output logic [AXI_AWIDTH-1:0]   S_AWADDR,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [AXI_DWIDTH-1:0]   S_WDATA,
  output logic [AXI_DWIDTH/8-1:0] S_WSTRB,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  input  logic [1:0]              S_BRESP,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  output logic [AXI_AWIDTH-1:0]   S_ARADDR,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   S_RDATA,
  input  logic [1:0]              S_RRESP,
  input  logic                    S_RVALID,
  output logic                    S_RREADY
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [1:0]    gnt;
  logic [CW-1:0] wait_cnt;
  logic          pick_m1, ar_take, contend, force_lose, r_hs;
  logic          aw_held, w_held, aw_done, w_done;
  logic          aw_take, w_take, b_done;

  // state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // read arbitration, slave AR issue and R routing
  always_comb begin
    r_next     = r_state;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    S_ARVALID  = 1'b0;
    S_RREADY   = 1'b0;
    M0_RVALID  = 1'b0;
    M0_RDATA   = '0;
    M0_RRESP   = '0;
    M1_RVALID  = 1'b0;
    M1_RDATA   = '0;
    M1_RRESP   = '0;
    pick_m1    = 1'b0;
    ar_take    = 1'b0;
    contend    = 1'b0;
    force_lose = 1'b0;
    r_hs       = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        contend    = M0_ARVALID && M1_ARVALID;
        force_lose = contend && (wait_cnt == CMAX);
        if (contend) pick_m1 = force_lose ? !PRIO_M1 : PRIO_M1;
        else         pick_m1 = M1_ARVALID;
        if (ARESETN && (M0_ARVALID || M1_ARVALID)) begin
          ar_take    = 1'b1;
          M1_ARREADY = pick_m1;
          M0_ARREADY = !pick_m1;
          r_next     = R_ADDR;
        end
      end
      R_ADDR: begin
        S_ARVALID = 1'b1;
        if (S_ARREADY) r_next = R_DATA;
      end
      R_DATA: begin
        if (gnt[1]) begin
          M1_RVALID = S_RVALID;
          M1_RDATA  = S_RDATA;
          M1_RRESP  = S_RRESP;
          r_hs      = S_RVALID && M1_RREADY;
          S_RREADY  = M1_RREADY;
        end else if (gnt[0]) begin
          M0_RVALID = S_RVALID;
          M0_RDATA  = S_RDATA;
          M0_RRESP  = S_RRESP;
          r_hs      = S_RVALID && M0_RREADY;
          S_RREADY  = M0_RREADY;
        end
        if (r_hs) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // latch read address, grant and starvation counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_ARADDR <= '0;
      gnt      <= '0;
      wait_cnt <= '0;
    end else if (ar_take) begin
      S_ARADDR <= pick_m1 ? M1_ARADDR : M0_ARADDR;
      gnt      <= {pick_m1, !pick_m1};
      if (!contend || force_lose) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // write collection, paired AW/W issue and B return
  always_comb begin
    w_next     = w_state;
    M1_AWREADY = 1'b0;
    M1_WREADY  = 1'b0;
    S_AWVALID  = 1'b0;
    S_WVALID   = 1'b0;
    S_BREADY   = 1'b0;
    M1_BVALID  = 1'b0;
    M1_BRESP   = '0;
    aw_take    = 1'b0;
    w_take     = 1'b0;
    b_done     = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        M1_AWREADY = ARESETN && !aw_held;
        M1_WREADY  = ARESETN && !w_held;
        aw_take    = M1_AWVALID && M1_AWREADY;
        w_take     = M1_WVALID && M1_WREADY;
        if ((aw_held || aw_take) && (w_held || w_take))
          w_next = W_REQ;
      end
      W_REQ: begin
        S_AWVALID = !aw_done;
        S_WVALID  = !w_done;
        if ((aw_done || S_AWREADY) && (w_done || S_WREADY))
          w_next = W_RESP;
      end
      W_RESP: begin
        M1_BVALID = S_BVALID;
        M1_BRESP  = S_BRESP;
        S_BREADY  = M1_BREADY;
        if (S_BVALID && M1_BREADY) begin
          b_done = 1'b1;
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // write payload buffer and per-channel progress flags
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AWADDR <= '0;
      S_WDATA  <= '0;
      S_WSTRB  <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (aw_take) begin
        S_AWADDR <= M1_AWADDR;
        aw_held  <= 1'b1;
      end
      if (w_take) begin
        S_WDATA <= M1_WDATA;
        S_WSTRB <= M1_WSTRB;
        w_held  <= 1'b1;
      end
      if (S_AWVALID && S_AWREADY) aw_done <= 1'b1;
      if (S_WVALID && S_WREADY)   w_done  <= 1'b1;
      if (b_done) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: directed bench for axi_mem_arbiter with a
// small responsive slave; inputs change on the falling edge.
module tb_axi_mem_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] M0_ARADDR;
  logic        M0_ARVALID;
  logic        M0_ARREADY;
  logic [31:0] M0_RDATA;
  logic [1:0]  M0_RRESP;
  logic        M0_RVALID;
  logic        M0_RREADY;
  logic [31:0] M1_AWADDR;
  logic        M1_AWVALID;
  logic        M1_AWREADY;
  logic [31:0] M1_WDATA;
  logic [3:0]  M1_WSTRB;
  logic        M1_WVALID;
  logic        M1_WREADY;
  logic [1:0]  M1_BRESP;
  logic        M1_BVALID;
  logic        M1_BREADY;
  logic [31:0] M1_ARADDR;
  logic        M1_ARVALID;
  logic        M1_ARREADY;
  logic [31:0] M1_RDATA;
  logic [1:0]  M1_RRESP;
  logic        M1_RVALID;
  logic        M1_RREADY;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;

  int checks = 0;
  int errors = 0;

  int          ar_stall = 0;
  logic        s_wr_block = 1'b0;
  logic [1:0]  rresp_knob = 2'b00;
  logic [1:0]  bresp_knob = 2'b00;

  axi_mem_arbiter #(
    .AXI_AWIDTH(32),
    .AXI_DWIDTH(32),
    .PRIO_M1(1'b1),
    .MAX_WAIT(2)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID),
    .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID),
    .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB),
    .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID),
    .M1_BREADY(M1_BREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID),
    .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID),
    .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
    .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  // slave: changes on falling edge, handshakes sampled at +2
  logic        hs_ar, hs_r, hs_aw, hs_w, hs_b;
  logic        got_aw, got_w;
  logic [31:0] ar_lat;
  int          ar_wait;

  initial begin : slave_model
    S_AWREADY = 0; S_WREADY = 0;
    S_BRESP = 0;   S_BVALID = 0;
    S_ARREADY = 0; S_RDATA = 0;
    S_RRESP = 0;   S_RVALID = 0;
    hs_ar = 0; hs_r = 0; hs_aw = 0;
    hs_w = 0;  hs_b = 0;
    got_aw = 0; got_w = 0;
    ar_lat = 0; ar_wait = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        S_AWREADY = 0; S_WREADY = 0;
        S_BVALID = 0;  S_ARREADY = 0;
        S_RVALID = 0;
        hs_ar = 0; hs_r = 0; hs_aw = 0;
        hs_w = 0;  hs_b = 0;
        got_aw = 0; got_w = 0; ar_wait = 0;
      end else begin
        if (hs_r) S_RVALID = 0;
        if (hs_ar) begin
          S_RVALID = 1;
          S_RDATA  = rdata_of(ar_lat);
          S_RRESP  = rresp_knob;
          ar_wait  = 0;
        end
        if (hs_b) S_BVALID = 0;
        if (hs_aw) got_aw = 1;
        if (hs_w) got_w = 1;
        if (got_aw && got_w) begin
          S_BVALID = 1;
          S_BRESP  = bresp_knob;
          got_aw   = 0;
          got_w    = 0;
        end
        #1;
        S_ARREADY = S_ARVALID && (ar_wait >= ar_stall);
        if (S_ARVALID && !S_ARREADY) ar_wait++;
        S_AWREADY = !s_wr_block;
        S_WREADY  = !s_wr_block;
        #1;
        hs_ar  = S_ARVALID && S_ARREADY;
        ar_lat = S_ARADDR;
        hs_r   = S_RVALID && S_RREADY;
        hs_aw  = S_AWVALID && S_AWREADY;
        hs_w   = S_WVALID && S_WREADY;
        hs_b   = S_BVALID && S_BREADY;
      end
    end
  end

  task automatic drive_idle();
    M0_ARADDR = 0; M0_ARVALID = 0; M0_RREADY = 0;
    M1_AWADDR = 0; M1_AWVALID = 0;
    M1_WDATA = 0;  M1_WSTRB = 0;  M1_WVALID = 0;
    M1_BREADY = 0;
    M1_ARADDR = 0; M1_ARVALID = 0; M1_RREADY = 0;
  endtask

  task automatic test_reset();
    logic [11:0] ctl;
    ARESETN = 0;
    drive_idle();
    M0_ARVALID = 1; M1_AWVALID = 1; M1_WVALID = 1;
    repeat (3) @(negedge ACLK);
    #3;
    ctl = {M0_ARREADY, M1_ARREADY, M1_AWREADY,
           M1_WREADY, M0_RVALID, M1_RVALID,
           M1_BVALID, S_ARVALID, S_AWVALID,
           S_WVALID, S_RREADY, S_BREADY};
    checks++;
    if (ctl !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctl: got %h expected 000", ctl);
    end
    checks++;
    if ({S_ARADDR, S_AWADDR, S_WDATA, S_WSTRB} !== '0) begin
      errors++;
      $display("FAIL reset_payload: got %h/%h/%h/%h expected 0",
               S_ARADDR, S_AWADDR, S_WDATA, S_WSTRB);
    end
    drive_idle();
    @(negedge ACLK);
    ARESETN = 1;
  endtask

  task automatic test_m0_read();
    logic m1_seen;
    drive_idle();
    m1_seen = 0;
    @(negedge ACLK);
    M0_ARADDR = 32'h100; M0_ARVALID = 1; M0_RREADY = 1;
    #3;
    checks++;
    if ({M0_ARREADY, M1_ARREADY} !== 2'b10) begin
      errors++;
      $display("FAIL m0rd_arready: got %b expected 10",
               {M0_ARREADY, M1_ARREADY});
    end
    @(negedge ACLK);
    M0_ARVALID = 0;
    #3;
    checks++;
    if (S_ARVALID !== 1'b1 || S_ARADDR !== 32'h100) begin
      errors++;
      $display("FAIL m0rd_saddr: got %b/%h expected 1/00000100",
               S_ARVALID, S_ARADDR);
    end
    @(negedge ACLK);
    #3;
    if (M1_RVALID) m1_seen = 1;
    checks++;
    if (M0_RVALID !== 1'b1 || M0_RDATA !== 32'hDEADBEEF
        || M0_RRESP !== 2'b00) begin
      errors++;
      $display("FAIL m0rd_data: got %b/%h/%b expected 1/deadbeef/00",
               M0_RVALID, M0_RDATA, M0_RRESP);
    end
    repeat (3) begin
      @(negedge ACLK);
      #3;
      if (M1_RVALID) m1_seen = 1;
    end
    checks++;
    if (m1_seen !== 1'b0) begin
      errors++;
      $display("FAIL m0rd_m1rvalid: got 1 expected 0");
    end
  endtask

  task automatic run_contention(input logic [31:0] a0,
                                input logic [31:0] a1,
                                input int n,
                                input logic [5:0] exp_seq);
    int got;
    got = 0;
    M0_ARADDR = a0; M1_ARADDR = a1;
    M0_RREADY = 1;  M1_RREADY = 1;
    for (int c = 0; c < 80 && got < n; c++) begin
      @(negedge ACLK);
      M0_ARVALID = 1; M1_ARVALID = 1;
      #3;
      if (M0_RVALID) begin
        checks++;
        if (M0_RDATA !== rdata_of(a0)) begin
          errors++;
          $display("FAIL arb_m0data: got %h expected %h",
                   M0_RDATA, rdata_of(a0));
        end
      end
      if (M1_RVALID) begin
        checks++;
        if (M1_RDATA !== rdata_of(a1)) begin
          errors++;
          $display("FAIL arb_m1data: got %h expected %h",
                   M1_RDATA, rdata_of(a1));
        end
      end
      if (M0_ARREADY || M1_ARREADY) begin
        checks++;
        if ((M0_ARREADY && M1_ARREADY)
            || M1_ARREADY !== exp_seq[got]) begin
          errors++;
          $display("FAIL arb_grant%0d: got m0=%b m1=%b expected m1=%b",
                   got, M0_ARREADY, M1_ARREADY, exp_seq[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL arb_timeout: got %0d grants expected %0d", got, n);
    end
    @(negedge ACLK);
    M0_ARVALID = 0; M1_ARVALID = 0;
    repeat (4) begin
      @(negedge ACLK);
      #3;
      if (M1_RVALID) begin
        checks++;
        if (M1_RDATA !== rdata_of(a1)) begin
          errors++;
          $display("FAIL arb_m1tail: got %h expected %h",
                   M1_RDATA, rdata_of(a1));
        end
      end
      if (M0_RVALID) begin
        checks++;
        if (M0_RDATA !== rdata_of(a0)) begin
          errors++;
          $display("FAIL arb_m0tail: got %h expected %h",
                   M0_RDATA, rdata_of(a0));
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_priority();
    drive_idle();
    run_contention(32'h10, 32'h20, 6, 6'b011011);
  endtask

  task automatic test_write();
    int bcount;
    drive_idle();
    M1_BREADY = 1;
    @(negedge ACLK);
    M1_AWADDR = 32'h40; M1_AWVALID = 1;
    #3;
    checks++;
    if (M1_AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL wr_awready: got %b expected 1", M1_AWREADY);
    end
    @(negedge ACLK);
    M1_AWVALID = 0;
    #3;
    checks++;
    if (M1_AWREADY !== 1'b0 || S_AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL wr_awheld: got %b/%b expected 0/0",
               M1_AWREADY, S_AWVALID);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    M1_WDATA = 32'h12345678; M1_WSTRB = 4'hF; M1_WVALID = 1;
    #3;
    checks++;
    if (M1_WREADY !== 1'b1 || S_AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL wr_wready: got %b/%b expected 1/0",
               M1_WREADY, S_AWVALID);
    end
    @(negedge ACLK);
    M1_WVALID = 0;
    #3;
    checks++;
    if ({S_AWVALID, S_WVALID} !== 2'b11) begin
      errors++;
      $display("FAIL wr_svalid: got %b expected 11",
               {S_AWVALID, S_WVALID});
    end
    checks++;
    if (S_AWADDR !== 32'h40 || S_WDATA !== 32'h12345678
        || S_WSTRB !== 4'hF) begin
      errors++;
      $display("FAIL wr_payload: got %h/%h/%h expected 40/12345678/f",
               S_AWADDR, S_WDATA, S_WSTRB);
    end
    bcount = 0;
    repeat (5) begin
      @(negedge ACLK);
      #3;
      if (M1_BVALID) begin
        bcount++;
        checks++;
        if (M1_BRESP !== 2'b00) begin
          errors++;
          $display("FAIL wr_bresp: got %b expected 00", M1_BRESP);
        end
      end
    end
    checks++;
    if (bcount != 1) begin
      errors++;
      $display("FAIL wr_bcount: got %0d expected 1", bcount);
    end
    drive_idle();
  endtask

  task automatic test_stall();
    logic exp_rr;
    drive_idle();
    ar_stall = 5;
    @(negedge ACLK);
    M0_ARADDR = 32'h200; M0_ARVALID = 1;
    #3;
    checks++;
    if (M0_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL st_arready: got %b expected 1", M0_ARREADY);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge ACLK);
      M0_ARVALID = 0;
      M1_ARADDR = 32'h300; M1_ARVALID = 1; M1_RREADY = 1;
      exp_rr = (c >= 10);
      M0_RREADY = exp_rr;
      #3;
      checks++;
      if (M1_ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL st_m1ar c%0d: got %b expected 0", c, M1_ARREADY);
      end
      if (c <= 6) begin
        checks++;
        if (S_ARVALID !== 1'b1 || S_ARADDR !== 32'h200) begin
          errors++;
          $display("FAIL st_addr c%0d: got %b/%h expected 1/00000200",
                   c, S_ARVALID, S_ARADDR);
        end
      end else begin
        checks++;
        if (S_RREADY !== exp_rr || M0_RVALID !== 1'b1
            || M1_RVALID !== 1'b0) begin
          errors++;
          $display("FAIL st_rdata c%0d: got %b/%b/%b expected %b/1/0",
                   c, S_RREADY, M0_RVALID, M1_RVALID, exp_rr);
        end
      end
    end
    checks++;
    if (M0_RDATA !== rdata_of(32'h200)) begin
      errors++;
      $display("FAIL st_m0data: got %h expected %h",
               M0_RDATA, rdata_of(32'h200));
    end
    ar_stall = 0;
    @(negedge ACLK);
    M0_RREADY = 0;
    #3;
    checks++;
    if (M1_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL st_m1grant: got %b expected 1", M1_ARREADY);
    end
    begin
      logic seen;
      seen = 0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge ACLK);
        M1_ARVALID = 0;
        #3;
        if (M1_RVALID) begin
          seen = 1;
          checks++;
          if (M1_RDATA !== rdata_of(32'h300)) begin
            errors++;
            $display("FAIL st_m1data: got %h expected %h",
                     M1_RDATA, rdata_of(32'h300));
          end
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL st_m1timeout: got no RVALID expected one");
      end
    end
    @(negedge ACLK);
    drive_idle();
  endtask

  task automatic test_concurrent();
    logic seen_r, seen_b, bad_m1r;
    drive_idle();
    rresp_knob = 2'b10;
    bresp_knob = 2'b01;
    seen_r = 0; seen_b = 0; bad_m1r = 0;
    @(negedge ACLK);
    M0_ARADDR = 32'h500; M0_ARVALID = 1; M0_RREADY = 1;
    M1_AWADDR = 32'h44; M1_AWVALID = 1;
    M1_WDATA = 32'hCAFEF00D; M1_WSTRB = 4'h3; M1_WVALID = 1;
    M1_BREADY = 1; M1_RREADY = 1;
    #3;
    checks++;
    if ({M0_ARREADY, M1_AWREADY, M1_WREADY} !== 3'b111) begin
      errors++;
      $display("FAIL cc_ready: got %b expected 111",
               {M0_ARREADY, M1_AWREADY, M1_WREADY});
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      M0_ARVALID = 0; M1_AWVALID = 0; M1_WVALID = 0;
      #3;
      if (M1_RVALID) bad_m1r = 1;
      if (S_WVALID) begin
        checks++;
        if (S_AWADDR !== 32'h44 || S_WDATA !== 32'hCAFEF00D
            || S_WSTRB !== 4'h3) begin
          errors++;
          $display("FAIL cc_wpay: got %h/%h/%h expected 44/cafef00d/3",
                   S_AWADDR, S_WDATA, S_WSTRB);
        end
      end
      if (M0_RVALID) begin
        seen_r = 1;
        checks++;
        if (M0_RDATA !== rdata_of(32'h500) || M0_RRESP !== 2'b10) begin
          errors++;
          $display("FAIL cc_rdata: got %h/%b expected %h/10",
                   M0_RDATA, M0_RRESP, rdata_of(32'h500));
        end
      end
      if (M1_BVALID) begin
        seen_b = 1;
        checks++;
        if (M1_BRESP !== 2'b01) begin
          errors++;
          $display("FAIL cc_bresp: got %b expected 01", M1_BRESP);
        end
      end
    end
    checks++;
    if ({seen_r, seen_b, bad_m1r} !== 3'b110) begin
      errors++;
      $display("FAIL cc_done: got r=%b b=%b m1r=%b expected 1/1/0",
               seen_r, seen_b, bad_m1r);
    end
    rresp_knob = 2'b00;
    bresp_knob = 2'b00;
    drive_idle();
  endtask

  task automatic test_async_reset();
    logic [11:0] ctl;
    drive_idle();
    s_wr_block = 1;
    @(negedge ACLK);
    M0_ARADDR = 32'h600; M0_ARVALID = 1;
    M1_ARADDR = 32'h700; M1_ARVALID = 1; M1_RREADY = 0;
    M1_AWADDR = 32'h48; M1_AWVALID = 1;
    M1_WDATA = 32'h55AA55AA; M1_WSTRB = 4'hC; M1_WVALID = 1;
    #3;
    checks++;
    if ({M0_ARREADY, M1_ARREADY} !== 2'b01) begin
      errors++;
      $display("FAIL ar_pregrant: got %b expected 01",
               {M0_ARREADY, M1_ARREADY});
    end
    @(negedge ACLK);
    M1_ARVALID = 0; M1_AWVALID = 0; M1_WVALID = 0;
    @(negedge ACLK);
    #3;
    checks++;
    if ({M1_RVALID, S_AWVALID, S_WVALID} !== 3'b111) begin
      errors++;
      $display("FAIL ar_midstate: got %b expected 111",
               {M1_RVALID, S_AWVALID, S_WVALID});
    end
    #1;
    ARESETN = 0;
    #1;
    ctl = {M0_ARREADY, M1_ARREADY, M1_AWREADY,
           M1_WREADY, M0_RVALID, M1_RVALID,
           M1_BVALID, S_ARVALID, S_AWVALID,
           S_WVALID, S_RREADY, S_BREADY};
    checks++;
    if (ctl !== 12'h000) begin
      errors++;
      $display("FAIL ar_ctl: got %h expected 000", ctl);
    end
    checks++;
    if ({S_ARADDR, S_AWADDR, S_WDATA, S_WSTRB} !== '0) begin
      errors++;
      $display("FAIL ar_payload: got %h/%h/%h/%h expected 0",
               S_ARADDR, S_AWADDR, S_WDATA, S_WSTRB);
    end
    drive_idle();
    s_wr_block = 0;
    repeat (2) @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1;
    run_contention(32'h10, 32'h8, 3, 6'b000011);
  endtask

  initial begin : main
    drive_idle();
    ARESETN = 0;
    test_reset();
    test_m0_read();
    test_priority();
    test_write();
    test_stall();
    test_concurrent();
    test_async_reset();
    repeat (2) @(negedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
